video_timing_gen: RTL and testbench

//  Raster timing and test-pattern source for the core. Generates pixel enable, H/V sync,
//  H/V blank and 8-bit luma (LFSR noise) from clk_sys. Feeds the emu top level, which

---
 rtl/video_timing_gen.sv | 182 ++++++++++++++++++
 tb/tb_video_timing_gen.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//   Raster timing and LFSR test-pattern source. A clock divider produces the
//   pixel strobe; horizontal/vertical counters walk the raster and every
//   timing/video output is registered on the divider's terminal count, so
//   consumers sample all outputs while ce_pix is high.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   pal         in   0 = NTSC field length, 1 = PAL (applied at field start)
//   scandouble  in   1 = 31 kHz mode, every field line emitted twice
//                    (applied at line start)
//   ce_pix      out  one-clk pixel strobe
//   HBlank      out  high outside the visible pixel range
//   HSync       out  active-high horizontal sync
//   VBlank      out  high outside the visible field lines
//   VSync       out  active-high vertical sync
//   video       out  8-bit luma, zero while blanked
//
// Strobe semantics: there is no back-pressure. ce_pix rises for exactly one
// clk per pixel period and the other outputs are stable whenever it is high.
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int CE_DIV        = 8,
  parameter int H_ACTIVE      = 320,
  parameter int H_TOTAL       = 384,
  parameter int HS_START      = 336,
  parameter int HS_END        = 364,
  parameter int V_ACTIVE      = 240,
  parameter int V_TOTAL_NTSC  = 262,
  parameter int V_TOTAL_PAL   = 312,
  parameter int VS_START_NTSC = 244,
  parameter int VS_START_PAL  = 270,
  parameter int VS_LEN        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pal,
  input  logic       scandouble,
  output logic       ce_pix,
  output logic       HBlank,
  output logic       HSync,
  output logic       VBlank,
  output logic       VSync,
  output logic [7:0] video
);

  localparam int V_MAX = (V_TOTAL_PAL > V_TOTAL_NTSC) ? V_TOTAL_PAL : V_TOTAL_NTSC;
  localparam int DW    = $clog2(CE_DIV);
  localparam int HW    = $clog2(H_TOTAL);
  localparam int VW    = $clog2(V_MAX);

  localparam logic [DW-1:0] DIV_LAST_N = DW'(CE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST_D = DW'(CE_DIV / 2 - 1);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_S       = HW'(HS_START);
  localparam logic [HW-1:0] HS_E       = HW'(HS_END);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VT_N_LAST  = VW'(V_TOTAL_NTSC - 1);
  localparam logic [VW-1:0] VT_P_LAST  = VW'(V_TOTAL_PAL - 1);
  localparam logic [VW-1:0] VS_N_S     = VW'(VS_START_NTSC);
  localparam logic [VW-1:0] VS_N_E     = VW'(VS_START_NTSC + VS_LEN);
  localparam logic [VW-1:0] VS_P_S     = VW'(VS_START_PAL);
  localparam logic [VW-1:0] VS_P_E     = VW'(VS_START_PAL + VS_LEN);
  localparam logic [15:0]   LFSR_SEED  = 16'hACE1;
  localparam logic [15:0]   LFSR_MASK  = 16'hB400;

  logic [DW-1:0] cdiv_q, cdiv_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          sub_q, sub_d;
  logic          pal_q, pal_d;
  logic          dbl_q, dbl_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          ce_pix_q, ce_pix_d;
  logic          hblank_q, hblank_d;
  logic          hsync_q, hsync_d;
  logic          vblank_q, vblank_d;
  logic          vsync_q, vsync_d;
  logic [7:0]    video_q, video_d;

  logic          ce_int;
  logic          h_act;
  logic          v_act;
  logic [VW-1:0] v_last;
  logic [VW-1:0] vs_s;
  logic [VW-1:0] vs_e;

  assign ce_int = (cdiv_q == (dbl_q ? DIV_LAST_D : DIV_LAST_N));
  assign h_act  = (h_q < H_ACT);
  assign v_act  = (v_q < V_ACT);
  // Field geometry follows the latched standard, never the live pal input.
  assign v_last = pal_q ? VT_P_LAST : VT_N_LAST;
  assign vs_s   = pal_q ? VS_P_S : VS_N_S;
  assign vs_e   = pal_q ? VS_P_E : VS_N_E;

  always_comb begin
    cdiv_d   = ce_int ? '0 : cdiv_q + DW'(1);
    h_d      = h_q;
    v_d      = v_q;
    sub_d    = sub_q;
    pal_d    = pal_q;
    dbl_d    = dbl_q;
    lfsr_d   = lfsr_q;
    ce_pix_d = ce_int;
    hblank_d = hblank_q;
    hsync_d  = hsync_q;
    vblank_d = vblank_q;
    vsync_d  = vsync_q;
    video_d  = video_q;
    if (ce_int) begin
      // Outputs describe the pixel at the current (h, v); counters then move on.
      hblank_d = !h_act;
      hsync_d  = (h_q >= HS_S) && (h_q < HS_E);
      vblank_d = !v_act;
      vsync_d  = (v_q >= vs_s) && (v_q < vs_e);
      video_d  = (h_act && v_act) ? lfsr_q[7:0] : 8'd0;
      if (h_act && v_act) begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
      end
      if (h_q == H_LAST) begin
        h_d   = '0;
        // The divider restarts at 0 here, so a rate change cannot glitch it.
        dbl_d = scandouble;
        sub_d = dbl_q ? ~sub_q : 1'b0;
        // In scandoubled mode the field line advances only after its repeat.
        if (!(dbl_q && !sub_q)) begin
          if (v_q == v_last) begin
            v_d   = '0;
            pal_d = pal;
          end else begin
            v_d = v_q + VW'(1);
          end
        end
      end else begin
        h_d = h_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cdiv_q   <= '0;
      h_q      <= '0;
      v_q      <= '0;
      sub_q    <= 1'b0;
      pal_q    <= pal;
      dbl_q    <= scandouble;
      lfsr_q   <= LFSR_SEED;
      ce_pix_q <= 1'b0;
      hblank_q <= 1'b1;
      hsync_q  <= 1'b0;
      vblank_q <= 1'b1;
      vsync_q  <= 1'b0;
      video_q  <= 8'd0;
    end else begin
      cdiv_q   <= cdiv_d;
      h_q      <= h_d;
      v_q      <= v_d;
      sub_q    <= sub_d;
      pal_q    <= pal_d;
      dbl_q    <= dbl_d;
      lfsr_q   <= lfsr_d;
      ce_pix_q <= ce_pix_d;
      hblank_q <= hblank_d;
      hsync_q  <= hsync_d;
      vblank_q <= vblank_d;
      vsync_q  <= vsync_d;
      video_q  <= video_d;
    end
  end

  assign ce_pix = ce_pix_q;
  assign HBlank = hblank_q;
  assign HSync  = hsync_q;
  assign VBlank = vblank_q;
  assign VSync  = vsync_q;
  assign video  = video_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//   Directed bench for video_timing_gen on a scaled-down raster so whole
//   fields fit in a short run. Walks complete fields pixel by pixel, checking
//   strobe spacing, blank/sync placement, line counts, LFSR luma, the
//   standard switch at field start, the scandoubled mode and a mid-field reset.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  localparam int CE_DIV        = 8;
  localparam int H_ACTIVE      = 16;
  localparam int H_TOTAL       = 24;
  localparam int HS_START      = 18;
  localparam int HS_END        = 21;
  localparam int V_ACTIVE      = 10;
  localparam int V_TOTAL_NTSC  = 14;
  localparam int V_TOTAL_PAL   = 18;
  localparam int VS_START_NTSC = 11;
  localparam int VS_START_PAL  = 13;
  localparam int VS_LEN        = 3;
  localparam int REC_N         = 2 * H_TOTAL;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pal = 1'b0;
  logic       scandouble = 1'b0;
  logic       ce_pix;
  logic       HBlank;
  logic       HSync;
  logic       VBlank;
  logic       VSync;
  logic [7:0] video;

  always #5 clk = ~clk;

  video_timing_gen #(
    .CE_DIV(CE_DIV), .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .HS_START(HS_START), .HS_END(HS_END), .V_ACTIVE(V_ACTIVE),
    .V_TOTAL_NTSC(V_TOTAL_NTSC), .V_TOTAL_PAL(V_TOTAL_PAL),
    .VS_START_NTSC(VS_START_NTSC), .VS_START_PAL(VS_START_PAL), .VS_LEN(VS_LEN)
  ) dut (
    .clk(clk), .reset(reset), .pal(pal), .scandouble(scandouble),
    .ce_pix(ce_pix), .HBlank(HBlank), .HSync(HSync), .VBlank(VBlank),
    .VSync(VSync), .video(video)
  );

  // scoreboard state
  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] mdl_lfsr;
  logic [11:0] ref_rec [REC_N];
  logic [11:0] cur_rec [REC_N];

  task automatic check_eq(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic report_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    check_eq("rst_ce_pix", ce_pix, 0);
    check_eq("rst_hblank", HBlank, 1);
    check_eq("rst_vblank", VBlank, 1);
    check_eq("rst_hsync",  HSync,  0);
    check_eq("rst_vsync",  VSync,  0);
    check_eq("rst_video",  video,  0);
    reset = 1'b0;
  endtask

  // Waits for the next strobe; gap = clks since the previous return.
  task automatic next_pix(output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!ce_pix && gap < 64);
    if (!ce_pix) begin
      check_eq("pix_timeout", gap, -1);
      report_and_finish();
    end
  endtask

  // Walks one complete field starting at output line 0, pixel 0.
  task automatic walk_field(input int vtot, input int vss, input bit dbl,
                            input int pal_at_line, input bit fresh);
    int div;
    int n_lines;
    int gap;
    int fl;
    int e_gap, e_hb, e_hs, e_vb, e_vs, e_vid;
    int act_lines, vs_lines, first_vs, hs_pix, rec_idx;
    bit exp_hb, exp_hs, exp_vb, exp_vs;
    logic [7:0] exp_vid;
    div = dbl ? CE_DIV / 2 : CE_DIV;
    n_lines = dbl ? 2 * vtot : vtot;
    e_gap = 0; e_hb = 0; e_hs = 0; e_vb = 0; e_vs = 0; e_vid = 0;
    act_lines = 0; vs_lines = 0; first_vs = -1; hs_pix = 0; rec_idx = 0;
    if (fresh) mdl_lfsr = 16'hACE1;
    for (int ol = 0; ol < n_lines; ol++) begin
      fl = dbl ? ol / 2 : ol;
      for (int h = 0; h < H_TOTAL; h++) begin
        next_pix(gap);
        if (ol == pal_at_line && h == 0) pal = 1'b1;
        exp_hb = (h >= H_ACTIVE);
        exp_hs = (h >= HS_START) && (h < HS_END);
        exp_vb = (fl >= V_ACTIVE);
        exp_vs = (fl >= vss) && (fl < vss + VS_LEN);
        if (!exp_hb && !exp_vb) begin
          exp_vid = mdl_lfsr[7:0];
          mdl_lfsr = lfsr_next(mdl_lfsr);
        end else begin
          exp_vid = 8'd0;
        end
        if (gap != div)      e_gap++;
        if (HBlank != exp_hb) e_hb++;
        if (HSync != exp_hs)  e_hs++;
        if (VBlank != exp_vb) e_vb++;
        if (VSync != exp_vs)  e_vs++;
        if (video != exp_vid) e_vid++;
        if (h == 0 && !VBlank) act_lines++;
        if (h == 0 && VSync) begin
          vs_lines++;
          if (first_vs < 0) first_vs = ol;
        end
        if (ol == 0 && HSync) hs_pix++;
        if (fresh && ol == 0 && h == 0) begin
          check_eq("first_gap",    gap, div);
          check_eq("first_video",  video, 8'hE1);
          check_eq("first_hblank", HBlank, 0);
          check_eq("first_vblank", VBlank, 0);
        end
        if (fresh && ol == 0 && h == 1) check_eq("second_video", video, 8'h70);
        if (fresh && ol == 0 && h == 2) check_eq("third_video",  video, 8'h38);
        if (rec_idx < REC_N) begin
          cur_rec[rec_idx] = {HBlank, HSync, VBlank, VSync, video};
          rec_idx++;
        end
      end
    end
    check_eq("gap_errs",    e_gap, 0);
    check_eq("hblank_errs", e_hb,  0);
    check_eq("hsync_errs",  e_hs,  0);
    check_eq("vblank_errs", e_vb,  0);
    check_eq("vsync_errs",  e_vs,  0);
    check_eq("video_errs",  e_vid, 0);
    check_eq("active_lines",  act_lines, dbl ? 2 * V_ACTIVE : V_ACTIVE);
    check_eq("vsync_lines",   vs_lines,  dbl ? 2 * VS_LEN : VS_LEN);
    check_eq("first_vs_line", first_vs,  dbl ? 2 * vss : vss);
    check_eq("hsync_pixels",  hs_pix,    HS_END - HS_START);
  endtask

  initial begin
    int gap;
    int mism;
    // NTSC from reset; keep the opening pixels as the reference sequence.
    pal = 1'b0;
    scandouble = 1'b0;
    do_reset(4);
    walk_field(V_TOTAL_NTSC, VS_START_NTSC, 1'b0, -1, 1'b1);
    for (int i = 0; i < REC_N; i++) ref_rec[i] = cur_rec[i];

    // pal rises mid-field: this field stays NTSC, the next one is PAL.
    walk_field(V_TOTAL_NTSC, VS_START_NTSC, 1'b0, 5, 1'b0);
    walk_field(V_TOTAL_PAL, VS_START_PAL, 1'b0, -1, 1'b0);

    // Into the next field up to line 8, pixel 10, then a one-clk reset.
    for (int i = 0; i < 8 * H_TOTAL + 11; i++) next_pix(gap);
    pal = 1'b0;
    do_reset(1);
    walk_field(V_TOTAL_NTSC, VS_START_NTSC, 1'b0, -1, 1'b1);
    mism = 0;
    for (int i = 0; i < REC_N; i++) if (cur_rec[i] !== ref_rec[i]) mism++;
    check_eq("post_reset_seq", mism, 0);

    // Scandoubled NTSC field from reset, then a following doubled field.
    scandouble = 1'b1;
    do_reset(2);
    walk_field(V_TOTAL_NTSC, VS_START_NTSC, 1'b1, -1, 1'b1);
    walk_field(V_TOTAL_NTSC, VS_START_NTSC, 1'b1, -1, 1'b0);

    report_and_finish();
  end

endmodule
